// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit-side byte FIFO that paces launches into a UART transmitter.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   wr_en      host write strobe
//   wr_data    byte to enqueue
//   full       count == depth (registered)
//   empty      count == 0 (registered)
//   count      bytes currently stored (registered)
//   overflow   one-cycle pulse when a write was dropped
//   tx_start   one-cycle launch pulse to the transmitter
//   tx_data    byte being sent, held between launches
//   tx_active  transmitter busy
//   done_tx    transmitter end-of-frame pulse
module uart_tx_fifo #(
    parameter int unsigned depth      = 16,
    parameter int unsigned addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_active,
    input  logic                  done_tx
);

    localparam int unsigned cnt_width = addr_width + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] GAP       = 2'd2;

    logic [7:0]            mem [depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  pop;
    logic                  wr_accept;
    logic                  tx_start_next;
    logic [7:0]            tx_data_next;
    logic [cnt_width-1:0]  count_next;

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign wr_accept = wr_en && !full;

    // Launch FSM: next state, pop request and next transmitter outputs.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data;
        case (state)
            IDLE: begin
                if (!empty && !tx_active) begin
                    pop           = 1'b1;
                    tx_start_next = 1'b1;
                    tx_data_next  = mem[rd_ptr];
                    state_next    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (done_tx) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                // Guard cycle so tx_active can fall before the next launch.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Occupancy update; accept and pop together leave count unchanged.
    always_comb begin
        count_next = count;
        case ({wr_accept, pop})
            2'b10:   count_next = count + cnt_width'(1);
            2'b01:   count_next = count - cnt_width'(1);
            default: count_next = count;
        endcase
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // State, pointers, flags and transmitter outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            state    <= state_next;
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == cnt_width'(depth));
            overflow <= wr_en && full;
            tx_start <= tx_start_next;
            tx_data  <= tx_data_next;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + addr_width'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + addr_width'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed self-checking bench for uart_tx_fifo with a transmitter stub.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_active;
    logic       done_tx;

    logic       stub_busy;
    logic       ext_busy;
    bit         stub_release;
    int         stub_delay;
    int         stub_timer;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic [7:0] launched [$];
    int         launch_cyc [$];
    int         ovf_pulses;
    int         max_count;
    bit         hold_err;
    logic [7:0] cur_byte;

    always #5 clk = ~clk;

    assign tx_active = stub_busy | ext_busy;

    uart_tx_fifo #(.depth(16), .addr_width(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_active (tx_active),
        .done_tx   (done_tx)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter stub plus monitors: done_tx arrives stub_delay cycles after tx_start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_busy  <= 1'b0;
            done_tx    <= 1'b0;
            stub_timer <= 0;
            ovf_pulses <= 0;
            max_count  <= 0;
            hold_err   <= 1'b0;
            cur_byte   <= 8'h00;
            launched.delete();
            launch_cyc.delete();
        end else begin
            done_tx <= 1'b0;
            if (overflow) ovf_pulses <= ovf_pulses + 1;
            if (int'(count) > max_count) max_count <= int'(count);
            if (tx_start) begin
                stub_busy  <= 1'b1;
                stub_timer <= 1;
                cur_byte   <= tx_data;
                launched.push_back(tx_data);
                launch_cyc.push_back(cyc);
            end else begin
                if (tx_data != cur_byte) hold_err <= 1'b1;
                if (stub_busy) begin
                    if (done_tx) stub_busy <= 1'b0;
                    else if (stub_release && (stub_timer + 1 >= stub_delay)) done_tx <= 1'b1;
                    stub_timer <= stub_timer + 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        wr_en = 1'b0; wr_data = 8'h00; ext_busy = 1'b0;
        stub_release = 1'b1; stub_delay = 8;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic wait_drain(input int n, output bit ok);
        int budget = 3000;
        while (budget > 0 && !(launched.size() >= n && empty && !tx_active && !done_tx && !tx_start)) begin
            step(1);
            budget--;
        end
        ok = (budget > 0);
        step(6);
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ext_busy = 1'b0;
        stub_release = 1'b1; stub_delay = 8;
        step(1);
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_empty: got %b want 1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b want 0", full); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL rst_tx_start: got %b want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_single_byte();
        bit ok;
        apply_reset();
        stub_delay = 20;
        wr_en = 1'b1; wr_data = 8'hA5;
        step(1);
        wr_en = 1'b0;
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL single_count_k1: got %0d want 1", count); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_k1: got %b want 0", tx_start); end
        step(1);
        vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL single_start_k2: got %b want 1", tx_start); end
        vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_data_k2: got %h want a5", tx_data); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL single_count_k2: got %0d want 0", count); end
        step(1);
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_start_k3: got %b want 0", tx_start); end
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL single_count_k3: got %0d want 0", count); end
        wait_drain(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 1) begin miscompares++; $display("FAIL single_pulses: got %0d want 1", launched.size()); end
        vectors++; if (hold_err !== 1'b0) begin miscompares++; $display("FAIL single_hold: got %b want 0", hold_err); end
    endtask

    task automatic test_burst_full();
        bit ok;
        int exp_cnt;
        apply_reset();
        stub_release = 1'b0;
        for (int i = 0; i < 19; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step(1);
            exp_cnt = (i == 0) ? 1 : ((i > 16) ? 16 : i);
            vectors++; if (overflow !== (i >= 17)) begin miscompares++; $display("FAIL burst_ovf[%0d]: got %b want %b", i, overflow, (i >= 17)); end
            vectors++; if (int'(count) != exp_cnt) begin miscompares++; $display("FAIL burst_count[%0d]: got %0d want %0d", i, count, exp_cnt); end
        end
        wr_en = 1'b0;
        step(1);
        vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL burst_full: got %b want 1", full); end
        vectors++; if (count !== 5'd16) begin miscompares++; $display("FAIL burst_count_end: got %0d want 16", count); end
        vectors++; if (launched.size() != 1) begin miscompares++; $display("FAIL burst_held_pulses: got %0d want 1", launched.size()); end
        vectors++; if (ovf_pulses != 2) begin miscompares++; $display("FAIL burst_ovf_pulses: got %0d want 2", ovf_pulses); end
        stub_release = 1'b1; stub_delay = 3;
        wait_drain(17, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL burst_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 17) begin miscompares++; $display("FAIL burst_len: got %0d want 17", launched.size()); end
        for (int j = 0; j < launched.size() && j < 17; j++) begin
            vectors++; if (launched[j] !== 8'(j)) begin miscompares++; $display("FAIL burst_order[%0d]: got %h want %h", j, launched[j], 8'(j)); end
        end
        vectors++; if (hold_err !== 1'b0) begin miscompares++; $display("FAIL burst_hold: got %b want 0", hold_err); end
    endtask

    task automatic test_pointer_wrap();
        bit ok;
        int idx = 0;
        int budget = 4000;
        apply_reset();
        stub_delay = 8;
        while (idx < 40 && budget > 0) begin
            if (!full) begin
                wr_en = 1'b1; wr_data = 8'(idx); idx++;
            end else begin
                wr_en = 1'b0;
            end
            step(1);
            budget--;
        end
        wr_en = 1'b0;
        wait_drain(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 40) begin miscompares++; $display("FAIL wrap_len: got %0d want 40", launched.size()); end
        for (int j = 0; j < launched.size() && j < 40; j++) begin
            vectors++; if (launched[j] !== 8'(j)) begin miscompares++; $display("FAIL wrap_order[%0d]: got %h want %h", j, launched[j], 8'(j)); end
        end
        for (int j = 1; j < launch_cyc.size(); j++) begin
            vectors++; if (launch_cyc[j] - launch_cyc[j-1] != 11) begin miscompares++; $display("FAIL wrap_spacing[%0d]: got %0d want 11", j, launch_cyc[j] - launch_cyc[j-1]); end
        end
        vectors++; if (max_count != 16) begin miscompares++; $display("FAIL wrap_max_count: got %0d want 16", max_count); end
        vectors++; if (ovf_pulses != 0) begin miscompares++; $display("FAIL wrap_ovf: got %0d want 0", ovf_pulses); end
        vectors++; if (hold_err !== 1'b0) begin miscompares++; $display("FAIL wrap_hold: got %b want 0", hold_err); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h51; exp_q[1] = 8'h52; exp_q[2] = 8'h53; exp_q[3] = 8'h54;
        apply_reset();
        stub_delay = 5;
        ext_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = exp_q[i];
            step(1);
        end
        wr_en = 1'b0;
        step(1);
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL simul_pre_count: got %0d want 3", count); end
        ext_busy = 1'b0; wr_en = 1'b1; wr_data = exp_q[3];
        step(1);
        wr_en = 1'b0;
        vectors++; if (count !== 5'd3) begin miscompares++; $display("FAIL simul_count: got %0d want 3", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL simul_ovf: got %b want 0", overflow); end
        vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL simul_start: got %b want 1", tx_start); end
        vectors++; if (tx_data !== 8'h51) begin miscompares++; $display("FAIL simul_data: got %h want 51", tx_data); end
        wait_drain(4, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL simul_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 4) begin miscompares++; $display("FAIL simul_len: got %0d want 4", launched.size()); end
        for (int j = 0; j < launched.size() && j < 4; j++) begin
            vectors++; if (launched[j] !== exp_q[j]) begin miscompares++; $display("FAIL simul_order[%0d]: got %h want %h", j, launched[j], exp_q[j]); end
        end
    endtask

    task automatic test_busy_holdoff();
        bit ok;
        apply_reset();
        stub_delay = 5;
        ext_busy = 1'b1;
        wr_en = 1'b1; wr_data = 8'h61; step(1);
        wr_data = 8'h62; step(1);
        wr_en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL busy_start[%0d]: got %b want 0", i, tx_start); end
        end
        vectors++; if (count !== 5'd2) begin miscompares++; $display("FAIL busy_count: got %0d want 2", count); end
        ext_busy = 1'b0;
        step(1);
        vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL busy_launch: got %b want 1", tx_start); end
        vectors++; if (tx_data !== 8'h61) begin miscompares++; $display("FAIL busy_data: got %h want 61", tx_data); end
        wait_drain(2, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL busy_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 2) begin miscompares++; $display("FAIL busy_len: got %0d want 2", launched.size()); end
        if (launched.size() == 2) begin
            vectors++; if (launched[1] !== 8'h62) begin miscompares++; $display("FAIL busy_second: got %h want 62", launched[1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        apply_reset();
        stub_release = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h70 + i);
            step(1);
        end
        wr_en = 1'b0;
        step(2);
        vectors++; if (count !== 5'd5) begin miscompares++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        vectors++; if (tx_data !== 8'h70) begin miscompares++; $display("FAIL mid_pre_data: got %h want 70", tx_data); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (count !== 5'd0) begin miscompares++; $display("FAIL mid_count: got %0d want 0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL mid_empty: got %b want 1", empty); end
        vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL mid_start: got %b want 0", tx_start); end
        vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_data: got %h want 00", tx_data); end
        step(1);
        rst = 1'b1; stub_release = 1'b1; stub_delay = 5;
        wr_en = 1'b1; wr_data = 8'h3C;
        step(1);
        wr_en = 1'b0;
        vectors++; if (count !== 5'd1) begin miscompares++; $display("FAIL mid_recover_count: got %0d want 1", count); end
        wait_drain(1, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL mid_timeout: got timeout want drained"); end
        vectors++; if (launched.size() != 1) begin miscompares++; $display("FAIL mid_len: got %0d want 1", launched.size()); end
        if (launched.size() == 1) begin
            vectors++; if (launched[0] !== 8'h3C) begin miscompares++; $display("FAIL mid_byte: got %h want 3c", launched[0]); end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; ext_busy = 1'b0;
        stub_release = 1'b1; stub_delay = 8;
        #1;
        test_reset();
        test_single_byte();
        test_burst_full();
        test_pointer_wrap();
        test_simultaneous();
        test_busy_holdoff();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
